// File: rtl/gamma_sched.sv
// Gamma-cycle scheduler: steps a run through N_LAYERS gamma cycles, drives the
// unit-time index, captures first-spike times in the final layer, and hands them to the host.
module gamma_sched #(
  parameter int N_OUT    = 8,
  parameter int T_W      = 4,
  parameter int N_LAYERS = 3
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   start,
  input  logic [T_W-1:0]         cfg_len,
  input  logic                   abort,
  input  logic [N_OUT-1:0]       edge_in,
  input  logic                   result_ack,
  output logic                   grst,
  output logic [N_LAYERS-1:0]    layer_en,
  output logic                   t_valid,
  output logic [T_W-1:0]         t_idx,
  output logic                   busy,
  output logic                   result_valid,
  output logic [N_OUT*T_W-1:0]   spike_time
);

  localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(N_LAYERS - 1);
  localparam logic [T_W-1:0] NOSPIKE = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GRST = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [T_W-1:0]         len_q, len_d;
  logic [LAYER_W-1:0]     layer_q, layer_d;
  logic [T_W-1:0]         t_cnt_q, t_cnt_d;
  logic [N_OUT*T_W-1:0]   spike_q, spike_d;
  logic [N_OUT-1:0]       flag_q, flag_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    layer_d = layer_q;
    t_cnt_d = t_cnt_q;
    spike_d = spike_q;
    flag_d  = flag_q;
    // Abort wins over everything except reset, including a same-cycle result_ack.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && cfg_len != '0) begin
            len_d   = cfg_len;
            layer_d = '0;
            state_d = S_GRST;
          end
        end
        S_GRST: begin
          t_cnt_d = '0;
          if (layer_q == LAST_LAYER) begin
            spike_d = {N_OUT{NOSPIKE}};
            flag_d  = '0;
          end
          state_d = S_RUN;
        end
        S_RUN: begin
          t_cnt_d = t_cnt_q + 1'b1;
          // First spike per line wins; the flag blocks later edges on that line.
          if (layer_q == LAST_LAYER) begin
            for (int i = 0; i < N_OUT; i++) begin
              if (edge_in[i] && !flag_q[i]) begin
                spike_d[i*T_W +: T_W] = t_cnt_q;
                flag_d[i]             = 1'b1;
              end
            end
          end
          if (t_cnt_q == len_q - 1'b1) begin
            if (layer_q == LAST_LAYER) begin
              state_d = S_DONE;
            end else begin
              layer_d = layer_q + 1'b1;
              state_d = S_GRST;
            end
          end
        end
        S_DONE: begin
          if (result_ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      layer_q <= '0;
      t_cnt_q <= '0;
      spike_q <= {N_OUT{NOSPIKE}};
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      layer_q <= layer_d;
      t_cnt_q <= t_cnt_d;
      spike_q <= spike_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    grst         = (state_q == S_GRST);
    t_valid      = (state_q == S_RUN);
    t_idx        = (state_q == S_RUN) ? t_cnt_q : '0;
    busy         = (state_q != S_IDLE);
    result_valid = (state_q == S_DONE);
    spike_time   = spike_q;
    layer_en     = '0;
    for (int k = 0; k < N_LAYERS; k++) begin
      layer_en[k] = (state_q == S_GRST || state_q == S_RUN) && (layer_q == LAYER_W'(k));
    end
  end

endmodule
